// File: rtl/lsu_pkg.sv
// Shared definitions for the split-access load/store unit: funct3 codes, FSM states
// and the access-size decoder.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        StIdle,
        StReq0,
        StWait0,
        StReq1,
        StWait1,
        StDone,
        StFault
    } lsu_state_t;

    typedef struct packed {
        logic [3:0] size;
        logic       legal;
    } lsu_size_t;

    // Stores only have signed-style encodings; D and WU exist only on a 64-bit datapath.
    function automatic lsu_size_t lsu_size_decode(input logic [2:0] funct3,
                                                  input logic       is_store,
                                                  input logic       xlen64);
        lsu_size_t r;
        r.size  = 4'd0;
        r.legal = 1'b0;
        case (funct3)
            F3_B:    begin r.size = 4'd1; r.legal = 1'b1;                end
            F3_H:    begin r.size = 4'd2; r.legal = 1'b1;                end
            F3_W:    begin r.size = 4'd4; r.legal = 1'b1;                end
            F3_D:    begin r.size = 4'd8; r.legal = xlen64;              end
            F3_BU:   begin r.size = 4'd1; r.legal = !is_store;           end
            F3_HU:   begin r.size = 4'd2; r.legal = !is_store;           end
            F3_WU:   begin r.size = 4'd4; r.legal = xlen64 && !is_store; end
            default: begin r.size = 4'd0; r.legal = 1'b0;                end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data assembly: shifts the two-beat read window down by the byte offset, then
// truncates and sign/zero-extends according to funct3.
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata0,
    input  logic [OFFW-1:0] off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] low;

    always_comb begin
        low = XLEN'({rdata1, rdata0} >> {off, 3'b000});
        case (funct3)
            F3_B:    result = XLEN'($signed(low[7:0]));
            F3_H:    result = XLEN'($signed(low[15:0]));
            F3_W:    result = XLEN'($signed(low[31:0]));
            F3_BU:   result = XLEN'(low[7:0]);
            F3_HU:   result = XLEN'(low[15:0]);
            F3_WU:   result = XLEN'(low[31:0]);
            F3_D:    result = low;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_split_access.sv
// Multi-cycle LSU with a valid/ready request port; misaligned accesses that straddle a bus
// word are issued as two beats on a single-outstanding bus.
module lsu_split_access
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] MMIO_BASE = 32'h4000_0000,
    parameter logic [31:0] MMIO_MASK = 32'hFFFF_0000,
    localparam int unsigned BYTES    = XLEN / 8,
    localparam int unsigned OFFW     = $clog2(BYTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             resp_valid,
    output logic [XLEN-1:0]  resp_rdata,
    output logic             resp_fault,
    output logic             bus_valid,
    input  logic             bus_ready,
    output logic             bus_write,
    output logic [XLEN-1:0]  bus_addr,
    output logic [XLEN-1:0]  bus_wdata,
    output logic [BYTES-1:0] bus_be,
    input  logic             bus_rvalid,
    input  logic [XLEN-1:0]  bus_rdata
);

    lsu_state_t       state_q, state_d;
    logic             write_q, write_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [OFFW-1:0]  off_q, off_d;
    logic             split_q, split_d;
    logic [XLEN-1:0]  b1_addr_q, b1_addr_d;
    logic [XLEN-1:0]  b1_wdata_q, b1_wdata_d;
    logic [BYTES-1:0] b1_be_q, b1_be_d;
    logic [XLEN-1:0]  rdata0_q, rdata0_d;

    logic             req_ready_q, req_ready_d;
    logic             bus_valid_q, bus_valid_d;
    logic             bus_write_q, bus_write_d;
    logic [XLEN-1:0]  bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]  bus_wdata_q, bus_wdata_d;
    logic [BYTES-1:0] bus_be_q, bus_be_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_fault_q, resp_fault_d;
    logic [XLEN-1:0]  resp_rdata_q, resp_rdata_d;

    lsu_size_t          dec;
    logic [OFFW-1:0]    req_off;
    logic [XLEN-1:0]    req_base;
    logic               req_mmio, req_misal, req_split, req_fault;
    logic [2*BYTES-1:0] mask_base, wide_be;
    logic [2*XLEN-1:0]  wide_wdata;

    logic [XLEN-1:0]    ext_rdata0, ext_rdata1, ext_result;

    // Request decode, evaluated on the incoming request so IDLE can load beat 0 directly.
    always_comb begin
        dec       = lsu_size_decode(req_funct3, req_write, XLEN == 64);
        req_off   = req_addr[OFFW-1:0];
        req_base  = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
        req_mmio  = (req_addr & XLEN'(MMIO_MASK)) == XLEN'(MMIO_BASE);
        req_misal = |(req_addr[3:0] & (dec.size - 4'd1));
        req_split = (32'(req_off) + 32'(dec.size)) > BYTES;
        req_fault = !dec.legal || (req_mmio && req_misal);
        mask_base = '0;
        for (int i = 0; i < int'(BYTES); i++) begin
            if (i < int'(dec.size)) mask_base[i] = 1'b1;
        end
        wide_be    = mask_base << req_off;
        wide_wdata = {{XLEN{1'b0}}, req_wdata} << {req_off, 3'b000};
    end

    // Beat data arrives on bus_rdata in the same cycle the result is registered.
    assign ext_rdata0 = (state_q == StWait0) ? bus_rdata : rdata0_q;
    assign ext_rdata1 = (state_q == StWait1) ? bus_rdata : '0;

    lsu_load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .rdata1 (ext_rdata1),
        .rdata0 (ext_rdata0),
        .off    (off_q),
        .funct3 (funct3_q),
        .result (ext_result)
    );

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        split_d      = split_q;
        b1_addr_d    = b1_addr_q;
        b1_wdata_d   = b1_wdata_q;
        b1_be_d      = b1_be_q;
        rdata0_d     = rdata0_q;
        req_ready_d  = req_ready_q;
        bus_valid_d  = bus_valid_q;
        bus_write_d  = bus_write_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;
        resp_valid_d = resp_valid_q;
        resp_fault_d = resp_fault_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    write_d     = req_write;
                    funct3_d    = req_funct3;
                    off_d       = req_off;
                    split_d     = req_split;
                    b1_addr_d   = req_base + XLEN'(BYTES);
                    b1_wdata_d  = wide_wdata[2*XLEN-1:XLEN];
                    b1_be_d     = wide_be[2*BYTES-1:BYTES];
                    if (req_fault) begin
                        state_d      = StFault;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d     = StReq0;
                        bus_valid_d = 1'b1;
                        bus_write_d = req_write;
                        bus_addr_d  = req_base;
                        bus_wdata_d = wide_wdata[XLEN-1:0];
                        bus_be_d    = wide_be[BYTES-1:0];
                    end
                end
            end
            StReq0: begin
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = StWait0;
                end
            end
            StWait0: begin
                if (bus_rvalid) begin
                    rdata0_d = bus_rdata;
                    if (split_q) begin
                        state_d     = StReq1;
                        bus_valid_d = 1'b1;
                        bus_addr_d  = b1_addr_q;
                        bus_wdata_d = b1_wdata_q;
                        bus_be_d    = b1_be_q;
                    end else begin
                        state_d      = StDone;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b0;
                        resp_rdata_d = write_q ? '0 : ext_result;
                    end
                end
            end
            StReq1: begin
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = StWait1;
                end
            end
            StWait1: begin
                if (bus_rvalid) begin
                    state_d      = StDone;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b0;
                    resp_rdata_d = write_q ? '0 : ext_result;
                end
            end
            StDone, StFault: begin
                state_d      = StIdle;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
            default: begin
                state_d      = StIdle;
                req_ready_d  = 1'b1;
                bus_valid_d  = 1'b0;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= '0;
            split_q      <= 1'b0;
            b1_addr_q    <= '0;
            b1_wdata_q   <= '0;
            b1_be_q      <= '0;
            rdata0_q     <= '0;
            req_ready_q  <= 1'b1;
            bus_valid_q  <= 1'b0;
            bus_write_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            split_q      <= split_d;
            b1_addr_q    <= b1_addr_d;
            b1_wdata_q   <= b1_wdata_d;
            b1_be_q      <= b1_be_d;
            rdata0_q     <= rdata0_d;
            req_ready_q  <= req_ready_d;
            bus_valid_q  <= bus_valid_d;
            bus_write_q  <= bus_write_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign bus_valid  = bus_valid_q;
    assign bus_write  = bus_write_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_be     = bus_be_q;
    assign resp_valid = resp_valid_q;
    assign resp_fault = resp_fault_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_split_access.sv
// Bench for lsu_split_access at XLEN=32: scoreboarded responses plus inline checks of the
// bus beats, timing, faults and reset behaviour.
module tb_lsu_split_access;
    import lsu_pkg::*;

    localparam int unsigned XLEN = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [XLEN-1:0]   req_addr = '0;
    logic [XLEN-1:0]   req_wdata = '0;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_fault;
    logic              bus_valid;
    logic              bus_ready = 1'b1;
    logic              bus_write;
    logic [XLEN-1:0]   bus_addr;
    logic [XLEN-1:0]   bus_wdata;
    logic [XLEN/8-1:0] bus_be;
    logic              bus_rvalid = 1'b0;
    logic [XLEN-1:0]   bus_rdata = '0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    lsu_split_access #(
        .XLEN      (XLEN),
        .MMIO_BASE (32'h4000_0000),
        .MMIO_MASK (32'hFFFF_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_write  (bus_write),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Response scoreboard: every resp_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: resp_valid at cycle %0d, none required", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (resp_rdata !== e.rdata || resp_fault !== e.fault || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL resp_%0d: rdata=%h fault=%b cyc=%0d, required %h %b %0d",
                             e.id, resp_rdata, resp_fault, cyc, e.rdata, e.fault, e.cyc);
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int h);
        bit got = 1'b0;
        h = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_ready) begin got = 1'b1; break; end
        end
        h = cyc;
        if (!got) begin
            errors++;
            $display("FAIL issue_timeout: req_ready stayed 0 for addr %h", a);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Waits for a beat, records its fields, then answers in the cycle after acceptance.
    task automatic serve_beat(input logic [31:0] rd, output logic [31:0] a,
                              output logic [3:0] be, output logic [31:0] wd,
                              output logic w, output int vc);
        bit got = 1'b0;
        a = '0; be = '0; wd = '0; w = 1'b0; vc = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus_valid) begin got = 1'b1; break; end
        end
        if (!got) begin
            errors++;
            $display("FAIL beat_timeout: bus_valid stayed 0, required 1");
        end else begin
            a = bus_addr; be = bus_be; wd = bus_wdata; w = bus_write; vc = cyc;
            @(posedge clk); #1;
            bus_rvalid = 1'b1; bus_rdata = rd;
            @(posedge clk); #1;
            bus_rvalid = 1'b0; bus_rdata = '0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++;
            $display("FAIL rst_req_ready: %b required 1", req_ready); end
        checks++; if (bus_valid !== 1'b0) begin errors++;
            $display("FAIL rst_bus_valid: %b required 0", bus_valid); end
        checks++; if (resp_valid !== 1'b0 || resp_fault !== 1'b0) begin errors++;
            $display("FAIL rst_resp: valid=%b fault=%b required 0 0", resp_valid, resp_fault); end
        checks++; if (bus_addr !== '0 || bus_wdata !== '0 || bus_be !== '0) begin errors++;
            $display("FAIL rst_bus_fields: %h %h %b required 0", bus_addr, bus_wdata, bus_be); end
        checks++; if (resp_rdata !== '0 || bus_write !== 1'b0) begin errors++;
            $display("FAIL rst_rdata: %h %b required 0", resp_rdata, bus_write); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || bus_valid !== 1'b0) begin errors++;
            $display("FAIL post_rst_idle: ready=%b bus_valid=%b required 1 0",
                     req_ready, bus_valid); end
    endtask

    task automatic test_load_word();
        int h, vc; logic [31:0] a, wd; logic [3:0] be; logic w;
        issue(1'b0, F3_W, 32'h100, '0, h);
        sb.push_back('{32'hDEAD_BEEF, 1'b0, h + 3, 1});
        serve_beat(32'hDEAD_BEEF, a, be, wd, w, vc);
        checks++; if (vc != h + 1) begin errors++;
            $display("FAIL lw_bus_cycle: %0d required %0d", vc, h + 1); end
        checks++; if (a !== 32'h100 || be !== 4'b1111 || w !== 1'b0) begin errors++;
            $display("FAIL lw_beat: addr=%h be=%b w=%b required 00000100 1111 0", a, be, w); end
        checks++; if (req_ready !== 1'b0) begin errors++;
            $display("FAIL lw_busy_ready: %b required 0", req_ready); end
        drain();
    endtask

    task automatic test_load_byte();
        int h, vc; logic [31:0] a, wd; logic [3:0] be; logic w;
        issue(1'b0, F3_B, 32'h103, '0, h);
        sb.push_back('{32'hFFFF_FF80, 1'b0, h + 3, 2});
        serve_beat(32'h8000_0000, a, be, wd, w, vc);
        checks++; if (a !== 32'h100 || be !== 4'b1000) begin errors++;
            $display("FAIL lb_beat: addr=%h be=%b required 00000100 1000", a, be); end
        drain();
        issue(1'b0, F3_BU, 32'h103, '0, h);
        sb.push_back('{32'h0000_0080, 1'b0, h + 3, 3});
        serve_beat(32'h8000_0000, a, be, wd, w, vc);
        checks++; if (be !== 4'b1000) begin errors++;
            $display("FAIL lbu_be: %b required 1000", be); end
        drain();
    endtask

    task automatic test_store_split();
        int h, vc0, vc1; logic [31:0] a0, a1, wd0, wd1; logic [3:0] be0, be1; logic w0, w1;
        issue(1'b1, F3_W, 32'h102, 32'h1122_3344, h);
        sb.push_back('{32'h0, 1'b0, h + 5, 4});
        serve_beat('0, a0, be0, wd0, w0, vc0);
        serve_beat('0, a1, be1, wd1, w1, vc1);
        checks++; if (a0 !== 32'h100 || be0 !== 4'b1100 || w0 !== 1'b1) begin errors++;
            $display("FAIL sw_beat0: addr=%h be=%b w=%b required 00000100 1100 1", a0, be0, w0); end
        checks++; if ((wd0 & 32'hFFFF_0000) !== 32'h3344_0000) begin errors++;
            $display("FAIL sw_wdata0: %h required 3344xxxx", wd0); end
        checks++; if (a1 !== 32'h104 || be1 !== 4'b0011 || w1 !== 1'b1) begin errors++;
            $display("FAIL sw_beat1: addr=%h be=%b w=%b required 00000104 0011 1", a1, be1, w1); end
        checks++; if ((wd1 & 32'h0000_FFFF) !== 32'h0000_1122) begin errors++;
            $display("FAIL sw_wdata1: %h required xxxx1122", wd1); end
        checks++; if (vc0 != h + 1 || vc1 != h + 3) begin errors++;
            $display("FAIL sw_beat_cycles: %0d %0d required %0d %0d", vc0, vc1, h + 1, h + 3); end
        drain();
    endtask

    task automatic test_half_wrap();
        int h, vc0, vc1; logic [31:0] a0, a1, wd; logic [3:0] be0, be1; logic w;
        issue(1'b0, F3_H, 32'hFFFF_FFFF, '0, h);
        sb.push_back('{32'hFFFF_CDAB, 1'b0, h + 5, 5});
        serve_beat(32'hAB00_0000, a0, be0, wd, w, vc0);
        serve_beat(32'h0000_00CD, a1, be1, wd, w, vc1);
        checks++; if (a0 !== 32'hFFFF_FFFC || be0 !== 4'b1000) begin errors++;
            $display("FAIL lh_wrap_beat0: addr=%h be=%b required fffffffc 1000", a0, be0); end
        checks++; if (a1 !== 32'h0 || be1 !== 4'b0001) begin errors++;
            $display("FAIL lh_wrap_beat1: addr=%h be=%b required 00000000 0001", a1, be1); end
        drain();
    endtask

    task automatic test_fault();
        int h; bit quiet;
        issue(1'b0, F3_W, 32'h4000_0002, '0, h);
        sb.push_back('{32'h0, 1'b1, h + 1, 6});
        quiet = 1'b1;
        repeat (4) begin @(negedge clk); if (bus_valid !== 1'b0) quiet = 1'b0; end
        checks++; if (!quiet) begin errors++;
            $display("FAIL mmio_fault_bus: bus_valid seen, required none"); end
        drain();
        issue(1'b0, F3_D, 32'h200, '0, h);
        sb.push_back('{32'h0, 1'b1, h + 1, 7});
        drain();
        issue(1'b1, F3_BU, 32'h200, 32'hFF, h);
        sb.push_back('{32'h0, 1'b1, h + 1, 8});
        drain();
    endtask

    task automatic test_back_to_back();
        int h1, h2, vc; logic [31:0] a, wd; logic [3:0] be; logic w;
        issue(1'b0, F3_W, 32'h4000_0010, '0, h1);
        sb.push_back('{32'h1234_5678, 1'b0, h1 + 3, 9});
        serve_beat(32'h1234_5678, a, be, wd, w, vc);
        issue(1'b0, F3_HU, 32'h4000_0012, '0, h2);
        sb.push_back('{32'h0000_BEEF, 1'b0, h2 + 3, 10});
        checks++; if (h2 != h1 + 4) begin errors++;
            $display("FAIL b2b_spacing: %0d cycles required 4", h2 - h1); end
        serve_beat(32'hBEEF_1234, a, be, wd, w, vc);
        checks++; if (a !== 32'h4000_0010 || be !== 4'b1100) begin errors++;
            $display("FAIL b2b_beat: addr=%h be=%b required 40000010 1100", a, be); end
        drain();
    endtask

    task automatic test_stall_reset();
        int h; bit stable, quiet; logic [31:0] a0; logic [3:0] be0;
        bus_ready = 1'b0;
        issue(1'b0, F3_W, 32'h300, '0, h);
        @(negedge clk);
        a0 = bus_addr; be0 = bus_be;
        stable = (bus_valid === 1'b1);
        repeat (3) begin
            @(negedge clk);
            if (bus_valid !== 1'b1 || bus_addr !== a0 || bus_be !== be0) stable = 1'b0;
        end
        checks++; if (!stable || a0 !== 32'h300) begin errors++;
            $display("FAIL stall_stable: stable=%b addr=%h required 1 00000300", stable, a0); end
        @(posedge clk); #1;
        bus_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || bus_valid !== 1'b0) begin errors++;
            $display("FAIL wait0_reset: ready=%b bus_valid=%b required 1 0", req_ready, bus_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus_rvalid = 1'b0; bus_rdata = '0;
        // Second abandon: reset while the beat is being presented must drop bus_valid at once.
        bus_ready = 1'b0;
        issue(1'b0, F3_W, 32'h400, '0, h);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus_valid !== 1'b0) begin errors++;
            $display("FAIL req0_async_reset: bus_valid=%b required 0", bus_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_ready = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || bus_valid !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++;
            $display("FAIL abandoned_access: activity after reset, required idle"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_split();
        test_half_wrap();
        test_fault();
        test_back_to_back();
        test_stall_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
